wide_add_sequencer: RTL and testbench

//  Multi-cycle wide adder front end. Accepts one WORDS*16-bit operand pair per transaction and

---
 rtl/adder_pkg.sv | 10 +
 rtl/adder_16bit.sv | 14 +
 rtl/wide_add_sequencer.sv | 128 ++++++++++++
 tb/tb_wide_add_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the wide adder sequencer: slice width and controller states.
package adder_pkg;
    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/adder_16bit.sv
// Purely combinational 16-bit slice adder with carry in and carry out.
module adder_16bit
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               Cin,
    output logic [SLICE_W-1:0] y,
    output logic               Co
);

    assign {Co, y} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, Cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// Serialises a WORDS*16-bit addition through one adder_16bit, LSB slice first,
// rippling the carry through a register and presenting the result on valid/ready.
module wide_add_sequencer
    import adder_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = SLICE_W * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic [W-1:0]       a_q, b_q;
    logic               capture;

    logic [SLICE_W-1:0] a_sl, b_sl, y_sl;
    logic               co_sl;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl = a_q[i*SLICE_W +: SLICE_W];
                b_sl = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    adder_16bit u_adder (
        .a   (a_sl),
        .b   (b_sl),
        .Cin (carry_q),
        .y   (y_sl),
        .Co  (co_sl)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    carry_d = cin;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = y_sl;
                    end
                end
                carry_d = co_sl;
                if (idx_q == LAST_IDX) begin
                    cout_d  = co_sl;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Result is held until taken; re-acceptance waits for IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Operand registers only matter once captured, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed vectors, corner sequences and
// randomized traffic against a queue-based arithmetic reference model.
module tb_wide_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [63:0] a, b, sum;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [15:0] a1, b1, sum1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    wide_add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        c;
    } vec_t;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called at #1 after an edge with the DUT in IDLE.
    task automatic do_txn(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                          output logic [63:0] rs, output logic rc, output int lat);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; cin = ~tc;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t        vecs[6];
    logic [63:0] rs;
    logic        rc;
    int          lat;
    logic [64:0] q[$];
    logic [64:0] exp_v;
    int          acc_n, take_n, pulses;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_in_ready",  65'(in_ready),  65'd1);
        chk("reset_out_valid", 65'(out_valid), 65'd0);
        chk("reset_sum",       65'(sum),       65'd0);
        chk("reset_cout",      65'(cout),      65'd0);
        chk("reset_busy",      65'(busy),      65'd0);

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h1_0000, 1'b0};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
                    64'h2345_6789_ABCD_F001, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};

        foreach (vecs[i]) begin
            chk($sformatf("vec%0d_in_ready", i), 65'(in_ready), 65'd1);
            do_txn(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
            chk($sformatf("vec%0d_sum", i),  65'(rs),  65'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 65'(rc),  65'(vecs[i].c));
            chk($sformatf("vec%0d_lat", i),  65'(lat), 65'd4);
        end

        // Backpressure in DONE with noisy inputs.
        a = 64'd100; b = 64'd23; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_sum_first", 65'(sum), 65'd123);
        for (int k = 0; k < 10; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1)); in_valid = ~in_valid; out_ready = 1'b0;
            @(posedge clk); #1;
            chk("bp_out_valid", 65'(out_valid), 65'd1);
            chk("bp_sum",       65'(sum),       65'd123);
            chk("bp_cout",      65'(cout),      65'd0);
            chk("bp_in_ready",  65'(in_ready),  65'd0);
        end
        in_valid = 1'b1; a = 64'd5; b = 64'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_take_out_valid", 65'(out_valid), 65'd0);
        chk("bp_take_in_ready",  65'(in_ready),  65'd1);
        chk("bp_no_bypass_busy", 65'(busy),      65'd0);

        // Reset while RUN is at slice 2.
        a = 64'h1111; b = 64'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_busy", 65'(busy), 65'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", 65'(out_valid), 65'd0);
        chk("rst_mid_sum",       65'(sum),       65'd0);
        chk("rst_mid_cout",      65'(cout),      65'd0);
        chk("rst_mid_in_ready",  65'(in_ready),  65'd1);
        chk("rst_mid_busy_lo",   65'(busy),      65'd0);
        pulses = 0;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rst_mid_no_result", 65'(pulses), 65'd0);
        do_txn(64'd3, 64'd4, 1'b0, rs, rc, lat);
        chk("rst_after_sum",  65'(rs), 65'd7);
        chk("rst_after_cout", 65'(rc), 65'd0);

        // WORDS=1 instance.
        a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b1; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w1_lat",  65'(lat),   65'd1);
        chk("w1_sum",  65'(sum1),  65'h1);
        chk("w1_cout", 65'(cout1), 65'd1);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("w1_taken", 65'(out_valid1), 65'd0);

        // Randomized traffic against the arithmetic model.
        acc_n = 0; take_n = 0;
        for (int cyc = 0; cyc < 40000 && acc_n < 1000; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = 64'h1;
            cin = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rnd_extra: result %h with nothing outstanding", {cout, sum});
                end else begin
                    exp_v = q.pop_front();
                    chk("rnd_result", {cout, sum}, exp_v);
                    take_n++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({1'b0, a} + {1'b0, b} + 65'(cin));
                acc_n++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() > 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_v = q.pop_front();
                chk("rnd_drain", {cout, sum}, exp_v);
                take_n++;
            end
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("rnd_accepted", 65'(acc_n),    65'd1000);
        chk("rnd_taken",    65'(take_n),   65'd1000);
        chk("rnd_pending",  65'(q.size()), 65'd0);
        chk("rnd_idle_end", 65'(out_valid), 65'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
